// File: rtl/vga_sprite_renderer.sv
// Sprite-over-background pixel stage: button-driven sprite position and a 2-cycle RGB/sync pipeline.
// Optional 1-pixel screen border is enabled by defining VGA_BORDER_EN.
module vga_sprite_renderer #(
    parameter int          H_VISIBLE  = 640,
    parameter int          V_VISIBLE  = 480,
    parameter int          SPRITE_W   = 32,
    parameter int          SPRITE_H   = 32,
    parameter int          STEP       = 4,
    parameter logic [11:0] SPRITE_RGB = 12'hF80,
    parameter logic [11:0] BG_RGB     = 12'h008,
    parameter logic [11:0] BORDER_RGB = 12'hFFF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    input  logic       is_blanking,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);

    localparam logic [10:0] X_MAX  = 11'(H_VISIBLE - SPRITE_W);
    localparam logic [10:0] Y_MAX  = 11'(V_VISIBLE - SPRITE_H);
    localparam logic [10:0] X_RST  = 11'((H_VISIBLE - SPRITE_W) / 2);
    localparam logic [10:0] Y_RST  = 11'((V_VISIBLE - SPRITE_H) / 2);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] SW_W   = 11'(SPRITE_W);
    localparam logic [10:0] SH_W   = 11'(SPRITE_H);

    // Button bit order: {up, down, left, right}
    logic [3:0]  btn_raw;
    logic [3:0]  btn_meta_q, btn_s_q;
    logic [3:0]  latch_q, latch_d;
    logic [3:0]  req;
    logic [10:0] x_q, x_d, y_q, y_d;
    logic        upd;
    logic        tick_q;

    logic        inside1_q, blank1_q, hs1_q, vs1_q;
    logic        inside_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hs2_q, vs2_q;
    logic [10:0] hc_w, vc_w;

    assign btn_raw = {btn_up, btn_down, btn_left, btn_right};
    assign upd     = (hc == 10'd0) && (vc == 10'(V_VISIBLE));
    assign req     = latch_q | btn_s_q;
    assign hc_w    = {1'b0, hc};
    assign vc_w    = {1'b0, vc};

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        latch_d = upd ? 4'b0000 : (latch_q | btn_s_q);
        if (upd) begin
            if (req[1] && !req[0])
                x_d = (x_q < STEP_W) ? 11'd0 : (x_q - STEP_W);
            else if (req[0] && !req[1])
                x_d = ((x_q + STEP_W) > X_MAX) ? X_MAX : (x_q + STEP_W);
            if (req[3] && !req[2])
                y_d = (y_q < STEP_W) ? 11'd0 : (y_q - STEP_W);
            else if (req[2] && !req[3])
                y_d = ((y_q + STEP_W) > Y_MAX) ? Y_MAX : (y_q + STEP_W);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            btn_meta_q <= '0;
            btn_s_q    <= '0;
            latch_q    <= '0;
            x_q        <= X_RST;
            y_q        <= Y_RST;
            tick_q     <= 1'b0;
        end else begin
            btn_meta_q <= btn_raw;
            btn_s_q    <= btn_meta_q;
            latch_q    <= latch_d;
            x_q        <= x_d;
            y_q        <= y_d;
            tick_q     <= upd;
        end
    end

    assign inside_d = (hc_w >= x_q) && (hc_w < x_q + SW_W) &&
                      (vc_w >= y_q) && (vc_w < y_q + SH_W);

`ifdef VGA_BORDER_EN
    logic border1_q;
    logic border_d;
    assign border_d = (hc == 10'd0) || (hc == 10'(H_VISIBLE - 1)) ||
                      (vc == 10'd0) || (vc == 10'(V_VISIBLE - 1));
    always_ff @(posedge CLK) begin
        if (RST) border1_q <= 1'b0;
        else     border1_q <= border_d;
    end
`endif

    // Stage-1 blank and syncs come out of reset inactive so the refill shows black, not background
    always_ff @(posedge CLK) begin
        if (RST) begin
            inside1_q <= 1'b0;
            blank1_q  <= 1'b1;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            rgb_q     <= 12'h000;
            hs2_q     <= 1'b1;
            vs2_q     <= 1'b1;
        end else begin
            inside1_q <= inside_d;
            blank1_q  <= is_blanking;
            hs1_q     <= hsync_in;
            vs1_q     <= vsync_in;
            rgb_q     <= rgb_d;
            hs2_q     <= hs1_q;
            vs2_q     <= vs1_q;
        end
    end

    always_comb begin
        rgb_d = BG_RGB;
        if (blank1_q)
            rgb_d = 12'h000;
        else if (inside1_q)
            rgb_d = SPRITE_RGB;
`ifdef VGA_BORDER_EN
        else if (border1_q)
            rgb_d = BORDER_RGB;
`endif
    end

    assign red        = rgb_q[11:8];
    assign green      = rgb_q[7:4];
    assign blue       = rgb_q[3:0];
    assign hsync      = hs2_q;
    assign vsync      = vs2_q;
    assign frame_tick = tick_q;

endmodule
